auth_request_scheduler: RTL and testbench
=========================================

// Module: auth_request_scheduler
// PURPOSE
// - Front-end scheduler for authentication_driver: queues auth requests from the PD and DEBUG requesters,
//   picks one by round-robin, drives it on pending_auth_request, holds it until the driver accepts it, then waits for completion.
// - Serializes access so the driver only ever sees one request. Adds a timeout so a stalled driver cannot block the queues.
// PARAMETERS
// - QUEUE_DEPTH     4     entries per requester queue; power of 2, >=2
// - TIMEOUT_CYCLES  1024  max cycles in WAIT_ACCEPT and in WAIT_DONE before abort; >=2
// - TMR_W           11    timer width; must hold TIMEOUT_CYCLES
// PORTS
// - clk             in   1  clock, all logic on posedge
// - reset           in   1  synchronous, active-high
// - pd_req_valid    in   1  PD request present
// - pd_req_cmd      in   4  {role[1:0], usb[1:0]}; role 01=responder, 10=initiator
// - pd_req_ready    out  1  PD queue not full; accept = valid & ready at posedge
// - dbg_req_valid   in   1  DEBUG request present
// - dbg_req_cmd     in   4  same format as pd_req_cmd
// - dbg_req_ready   out  1  DEBUG queue not full
// - pending_auth_request out 8  to driver: {requester[1:0], role[1:0], usb[1:0], 2'b00}; 0 = none
// - PD_in_ready     in   1  driver accepted the PD request
// - DEBUG_in_ready  in   1  driver accepted the DEBUG request
// - auth_msg_ready  in   1  driver finished; message available
// - pd_done         out  1  1-cycle pulse: PD request completed
// - dbg_done        out  1  1-cycle pulse: DEBUG request completed
// - cmd_err         out  1  1-cycle pulse: popped cmd had role 00/11; dropped
// - timeout_err     out  1  1-cycle pulse: request aborted on timeout
// - busy            out  1  high in any state other than IDLE
// BEHAVIOUR
// - Reset: all outputs 0, except pd_req_ready = dbg_req_ready = 1. Both queues empty. last_grant = DEBUG, so PD wins first.
//   Timer is 0 and state is IDLE. Reset mid-transaction drops everything; pending_auth_request is 0 on the next cycle.
// - Queues: each is a FIFO. ready = !full, with no bypass.
//   A push and a pop in the same cycle are both honoured, so the count is unchanged.
//   When full, ready stays low even if a pop happens in that same cycle.
// - FSM states: IDLE, WAIT_ACCEPT, WAIT_DONE, RELEASE.
//   IDLE:
//   - If either queue is non-empty, grant it. If both are non-empty, grant the one that is not last_grant.
//   - Pop the granted head and update last_grant.
//   - Role valid: load pending_auth_request with requester 01 for PD or 10 for DEBUG, clear timer, go to WAIT_ACCEPT.
//   - Role invalid: pulse cmd_err, leave pending at 0, stay in IDLE. Arbitration runs again next cycle.
//   WAIT_ACCEPT:
//   - Hold pending_auth_request stable.
//   - The accept strobe must match the granted requester: PD_in_ready for PD, DEBUG_in_ready for DEBUG.
//     On the matching strobe, clear pending to 0 and the timer, go to WAIT_DONE. A non-matching strobe is ignored.
//   WAIT_DONE:
//   - pending stays 0.
//   - On auth_msg_ready, pulse pd_done or dbg_done for the granted requester and go to RELEASE.
//   Timeout: in WAIT_ACCEPT or WAIT_DONE, the timer increments every cycle.
//   - At timer == TIMEOUT_CYCLES-1 with no event, pulse timeout_err, clear pending, go to RELEASE.
//   - If the event and the expiry fall in the same cycle, the event wins.
//   RELEASE: one cycle with pending 0 so the driver returns to its IDLE. Then go to IDLE.
// - Latency: a request accepted at edge N into an empty, idle scheduler gives pending != 0 after edge N+2.
//   Minimum gap between two grants is 2 cycles (RELEASE, then IDLE).
// - Queue pushes continue during every state.
// - done/err pulses are registered outputs; all are mutually exclusive.
// STRUCTURE
// - Shared constants go in Parameters.v:
//   - REQ_PD = 2'b01, REQ_DEBUG = 2'b10
//   - ROLE_RESP = 2'b01, ROLE_INIT = 2'b10
//   - SIZE_OF_STATES_SCHED with one-hot state encodings
// - One sub-module: auth_req_fifo (param DEPTH, WIDTH=4). Two instances, one for PD and one for DEBUG.
// - Arbiter, FSM and timer stay in the top level.
// TESTING
// - Single PD req (cmd 4'b0100) -> pending = 8'h50 after 2 edges; PD_in_ready -> pending 0.
//   Then auth_msg_ready -> pd_done pulse, busy low 2 cycles later.
// - PD and DEBUG both queued -> grants alternate PD, DBG, PD, DBG. pending toggles 8'h50/8'h90 for role 01, usb 00.
// - Push 4 PD reqs with the scheduler stalled in WAIT_ACCEPT -> pd_req_ready = 0 after the 4th; a 5th valid is not accepted.
//   After one pop completes, ready = 1.
// - DEBUG cmd 4'b1100 (role 11) -> cmd_err pulse, pending stays 0, next queued req granted the following cycle.
// - No PD_in_ready for TIMEOUT_CYCLES -> timeout_err at cycle 1023, pending 0, RELEASE, then next request.
//   Also cover auth_msg_ready arriving at the expiry cycle -> done pulse, no timeout_err.
// - Reset asserted in WAIT_DONE -> pending 0, busy 0, both ready 1, queues empty, no done pulse.

Source files
------------

// File: rtl/auth_request_scheduler_pkg.sv
// Shared constants, state encoding and small helpers for the auth request scheduler.
// Pending word layout towards the driver: {requester[1:0], role[1:0], usb[1:0], 2'b00}.
package auth_request_scheduler_pkg;

    localparam logic [1:0] REQ_PD    = 2'b01;
    localparam logic [1:0] REQ_DEBUG = 2'b10;

    localparam logic [1:0] ROLE_RESP = 2'b01;
    localparam logic [1:0] ROLE_INIT = 2'b10;

    localparam int unsigned SIZE_OF_STATES_SCHED = 4;

    typedef enum logic [SIZE_OF_STATES_SCHED-1:0] {
        StIdle       = 4'b0001,
        StWaitAccept = 4'b0010,
        StWaitDone   = 4'b0100,
        StRelease    = 4'b1000
    } sched_state_e;

    // {role[1:0], usb[1:0]}
    typedef logic [3:0] auth_cmd_t;

    function automatic logic role_valid(auth_cmd_t cmd);
        return (cmd[3:2] == ROLE_RESP) || (cmd[3:2] == ROLE_INIT);
    endfunction

    function automatic logic [7:0] pack_pending(logic [1:0] requester, auth_cmd_t cmd);
        return {requester, cmd, 2'b00};
    endfunction

endpackage

// File: rtl/auth_request_scheduler_if.sv
// Requester and driver facing signals of the auth request scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface auth_request_scheduler_if;

    logic       pd_req_valid;
    logic [3:0] pd_req_cmd;
    logic       pd_req_ready;
    logic       dbg_req_valid;
    logic [3:0] dbg_req_cmd;
    logic       dbg_req_ready;
    logic [7:0] pending_auth_request;
    logic       PD_in_ready;
    logic       DEBUG_in_ready;
    logic       auth_msg_ready;
    logic       pd_done;
    logic       dbg_done;
    logic       cmd_err;
    logic       timeout_err;
    logic       busy;

    modport master (
        output pd_req_valid,
        output pd_req_cmd,
        input  pd_req_ready,
        output dbg_req_valid,
        output dbg_req_cmd,
        input  dbg_req_ready,
        input  pending_auth_request,
        output PD_in_ready,
        output DEBUG_in_ready,
        output auth_msg_ready,
        input  pd_done,
        input  dbg_done,
        input  cmd_err,
        input  timeout_err,
        input  busy
    );

    modport slave (
        input  pd_req_valid,
        input  pd_req_cmd,
        output pd_req_ready,
        input  dbg_req_valid,
        input  dbg_req_cmd,
        output dbg_req_ready,
        output pending_auth_request,
        input  PD_in_ready,
        input  DEBUG_in_ready,
        input  auth_msg_ready,
        output pd_done,
        output dbg_done,
        output cmd_err,
        output timeout_err,
        output busy
    );

endinterface

// File: rtl/auth_req_fifo.sv
// Per-requester request FIFO. ready = !full with no bypass; an entry becomes
// poppable one cycle after it is stored, which sets the two-edge request latency.
module auth_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             ready,
    input  logic             pop,
    output logic             avail,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    DepthCnt = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pushed_q;
    logic [AW:0]      readable;
    logic             push_ok;
    logic             pop_ok;

    assign ready    = (count_q != DepthCnt);
    // The entry written on the previous edge is not yet visible to the reader.
    assign readable = count_q - (AW+1)'(pushed_q);
    assign avail    = (readable != '0);
    assign push_ok  = push & ready;
    assign pop_ok   = pop & avail;
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pushed_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q  <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            pushed_q <= push_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/auth_request_scheduler.sv
// Round-robin front end for the authentication driver: one request in flight at
// a time, held until accepted, then tracked to completion with a timeout guard.
module auth_request_scheduler
    import auth_request_scheduler_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TMR_W          = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    auth_request_scheduler_if.slave  bus
);

    sched_state_e     state_q;
    logic [1:0]       last_q;
    logic [1:0]       owner_q;
    logic [7:0]       pending_q;
    logic [TMR_W-1:0] tmr_q;
    logic             pd_done_q;
    logic             dbg_done_q;
    logic             cmd_err_q;
    logic             timeout_err_q;

    logic       pd_avail;
    logic       dbg_avail;
    logic       pd_ready;
    logic       dbg_ready;
    auth_cmd_t  pd_head;
    auth_cmd_t  dbg_head;
    logic       gnt_pd;
    logic       gnt_dbg;
    auth_cmd_t  gnt_cmd;
    logic [1:0] gnt_req;
    logic       accept_hit;
    logic       expired;

    auth_req_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (4)
    ) u_pd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.pd_req_valid),
        .push_data (bus.pd_req_cmd),
        .ready     (pd_ready),
        .pop       (gnt_pd),
        .avail     (pd_avail),
        .head      (pd_head)
    );

    auth_req_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (4)
    ) u_dbg_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.dbg_req_valid),
        .push_data (bus.dbg_req_cmd),
        .ready     (dbg_ready),
        .pop       (gnt_dbg),
        .avail     (dbg_avail),
        .head      (dbg_head)
    );

    // Arbitration is only live in IDLE; on contention the requester not granted last wins.
    always_comb begin
        gnt_pd  = 1'b0;
        gnt_dbg = 1'b0;
        if (state_q == StIdle) begin
            if (pd_avail && dbg_avail) begin
                gnt_pd  = (last_q == REQ_DEBUG);
                gnt_dbg = (last_q != REQ_DEBUG);
            end else begin
                gnt_pd  = pd_avail;
                gnt_dbg = dbg_avail;
            end
        end
    end

    assign gnt_cmd    = gnt_pd ? pd_head : dbg_head;
    assign gnt_req    = gnt_pd ? REQ_PD : REQ_DEBUG;
    assign accept_hit = (owner_q == REQ_PD) ? bus.PD_in_ready : bus.DEBUG_in_ready;
    assign expired    = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            last_q        <= REQ_DEBUG;
            owner_q       <= REQ_PD;
            pending_q     <= '0;
            tmr_q         <= '0;
            pd_done_q     <= 1'b0;
            dbg_done_q    <= 1'b0;
            cmd_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            pd_done_q     <= 1'b0;
            dbg_done_q    <= 1'b0;
            cmd_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_pd || gnt_dbg) begin
                        last_q  <= gnt_req;
                        owner_q <= gnt_req;
                        if (role_valid(gnt_cmd)) begin
                            pending_q <= pack_pending(gnt_req, gnt_cmd);
                            tmr_q     <= '0;
                            state_q   <= StWaitAccept;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end
                StWaitAccept: begin
                    // A strobe on the expiry cycle still counts as an accept.
                    if (accept_hit) begin
                        pending_q <= '0;
                        tmr_q     <= '0;
                        state_q   <= StWaitDone;
                    end else if (expired) begin
                        timeout_err_q <= 1'b1;
                        pending_q     <= '0;
                        state_q       <= StRelease;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                StWaitDone: begin
                    if (bus.auth_msg_ready) begin
                        pd_done_q  <= (owner_q == REQ_PD);
                        dbg_done_q <= (owner_q != REQ_PD);
                        state_q    <= StRelease;
                    end else if (expired) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= StRelease;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                StRelease: begin
                    state_q <= StIdle;
                end
                default: begin
                    pending_q <= '0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign bus.pd_req_ready         = pd_ready;
    assign bus.dbg_req_ready        = dbg_ready;
    assign bus.pending_auth_request = pending_q;
    assign bus.pd_done              = pd_done_q;
    assign bus.dbg_done             = dbg_done_q;
    assign bus.cmd_err              = cmd_err_q;
    assign bus.timeout_err          = timeout_err_q;
    assign bus.busy                 = (state_q != StIdle);

endmodule

// File: tb/tb_auth_request_scheduler.sv
// Bench for auth_request_scheduler: directed scenarios with literal expectations,
// then random traffic, all shadowed cycle by cycle by a queue-based reference model.
module tb_auth_request_scheduler;

    localparam int DEPTH = 4;
    localparam int TOUT  = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    auth_request_scheduler_if bus ();

    auth_request_scheduler #(
        .QUEUE_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES (TOUT),
        .TMR_W          (11)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;

    // Reference model: queues of commands plus the phase of the in-flight request.
    logic [3:0] m_pdq[$];
    logic [3:0] m_dbgq[$];
    bit         m_pd_new, m_dbg_new;
    int         m_phase;      // 0 idle, 1 awaiting accept, 2 awaiting done, 3 release
    int         m_owner;      // 1 PD, 2 DEBUG
    int         m_last;
    int         m_wait;       // cycles spent in the current wait phase
    logic [7:0] m_pending;
    bit         m_pd_done, m_dbg_done, m_cmd_err, m_tout;

    function automatic bit good_role(logic [3:0] c);
        return (c[3:2] == 2'b01) || (c[3:2] == 2'b10);
    endfunction

    task automatic model_step();
        bit         pd_acc, dbg_acc, pa, da, ev;
        int         g;
        logic [3:0] c;
        if (reset) begin
            m_pdq.delete();
            m_dbgq.delete();
            m_pd_new = 0; m_dbg_new = 0;
            m_phase = 0; m_owner = 1; m_last = 2; m_wait = 0;
            m_pending = 8'h00;
            m_pd_done = 0; m_dbg_done = 0; m_cmd_err = 0; m_tout = 0;
            return;
        end
        pd_acc  = bus.pd_req_valid && (m_pdq.size() < DEPTH);
        dbg_acc = bus.dbg_req_valid && (m_dbgq.size() < DEPTH);
        m_pd_done = 0; m_dbg_done = 0; m_cmd_err = 0; m_tout = 0;
        case (m_phase)
            0: begin
                pa = (m_pdq.size() - int'(m_pd_new)) > 0;
                da = (m_dbgq.size() - int'(m_dbg_new)) > 0;
                if (pa && da) g = (m_last == 2) ? 1 : 2;
                else if (pa)  g = 1;
                else if (da)  g = 2;
                else          g = 0;
                if (g != 0) begin
                    c = (g == 1) ? m_pdq.pop_front() : m_dbgq.pop_front();
                    m_last = g;
                    if (good_role(c)) begin
                        m_owner   = g;
                        m_pending = {2'(g), c, 2'b00};
                        m_wait    = 0;
                        m_phase   = 1;
                    end else begin
                        m_cmd_err = 1;
                    end
                end
            end
            1: begin
                ev = (m_owner == 1) ? bus.PD_in_ready : bus.DEBUG_in_ready;
                if (ev) begin
                    m_pending = 8'h00; m_wait = 0; m_phase = 2;
                end else if (m_wait == TOUT - 1) begin
                    m_tout = 1; m_pending = 8'h00; m_phase = 3;
                end else begin
                    m_wait++;
                end
            end
            2: begin
                if (bus.auth_msg_ready) begin
                    if (m_owner == 1) m_pd_done = 1; else m_dbg_done = 1;
                    m_phase = 3;
                end else if (m_wait == TOUT - 1) begin
                    m_tout = 1; m_phase = 3;
                end else begin
                    m_wait++;
                end
            end
            default: m_phase = 0;
        endcase
        if (pd_acc)  m_pdq.push_back(bus.pd_req_cmd);
        if (dbg_acc) m_dbgq.push_back(bus.dbg_req_cmd);
        m_pd_new  = pd_acc;
        m_dbg_new = dbg_acc;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // Per-cycle compare of every output against the model.
    initial begin
        logic [14:0] dut_v, exp_v;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            dut_v = {bus.pending_auth_request, bus.pd_req_ready, bus.dbg_req_ready,
                     bus.pd_done, bus.dbg_done, bus.cmd_err, bus.timeout_err, bus.busy};
            exp_v = {m_pending, 1'(m_pdq.size() < DEPTH), 1'(m_dbgq.size() < DEPTH),
                     m_pd_done, m_dbg_done, m_cmd_err, m_tout, 1'(m_phase != 0)};
            chk("model_cycle", 32'(dut_v), 32'(exp_v));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle_inputs();
        bus.pd_req_valid   = 1'b0;
        bus.pd_req_cmd     = 4'h0;
        bus.dbg_req_valid  = 1'b0;
        bus.dbg_req_cmd    = 4'h0;
        bus.PD_in_ready    = 1'b0;
        bus.DEBUG_in_ready = 1'b0;
        bus.auth_msg_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick_n(2);
        reset = 1'b0;
    endtask

    task automatic wait_pending(output logic [7:0] v);
        int n = 0;
        while (bus.pending_auth_request == 8'h00 && n < 64) begin
            tick();
            n++;
        end
        v = bus.pending_auth_request;
    endtask

    // Accept the pending request, complete it, and return in IDLE.
    task automatic serve();
        logic [7:0] p;
        p = bus.pending_auth_request;
        if (p[7:6] == 2'b01) bus.PD_in_ready = 1'b1;
        else                 bus.DEBUG_in_ready = 1'b1;
        tick();
        bus.PD_in_ready    = 1'b0;
        bus.DEBUG_in_ready = 1'b0;
        bus.auth_msg_ready = 1'b1;
        tick();
        bus.auth_msg_ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] v;
        logic [3:0] full_cmds [4];
        logic [7:0] full_exp  [4];
        logic [7:0] alt_exp   [2];
        full_cmds[0] = 4'b0100; full_cmds[1] = 4'b1000;
        full_cmds[2] = 4'b0101; full_cmds[3] = 4'b1010;
        full_exp[0]  = 8'h50;   full_exp[1]  = 8'h60;
        full_exp[2]  = 8'h54;   full_exp[3]  = 8'h68;
        alt_exp[0]   = 8'h50;   alt_exp[1]   = 8'h90;

        reset = 1'b1;
        idle_inputs();
        tick_n(2);
        reset = 1'b0;
        chk("reset_pending", 32'(bus.pending_auth_request), 32'h00);
        chk("reset_pd_ready", 32'(bus.pd_req_ready), 32'd1);
        chk("reset_dbg_ready", 32'(bus.dbg_req_ready), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);

        // Single PD request, two-edge latency.
        bus.pd_req_valid = 1'b1; bus.pd_req_cmd = 4'b0100;
        tick();
        bus.pd_req_valid = 1'b0;
        chk("single_edge1", 32'(bus.pending_auth_request), 32'h00);
        tick();
        chk("single_edge2", 32'(bus.pending_auth_request), 32'h00);
        tick();
        chk("single_grant", 32'(bus.pending_auth_request), 32'h50);
        chk("single_model", 32'(m_pending), 32'h50);
        chk("single_busy", 32'(bus.busy), 32'd1);
        bus.PD_in_ready = 1'b1;
        tick();
        bus.PD_in_ready = 1'b0;
        chk("single_accept", 32'(bus.pending_auth_request), 32'h00);
        tick();
        bus.auth_msg_ready = 1'b1;
        tick();
        bus.auth_msg_ready = 1'b0;
        chk("single_pd_done", 32'(bus.pd_done), 32'd1);
        chk("single_release_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("single_idle_busy", 32'(bus.busy), 32'd0);
        chk("single_done_once", 32'(bus.pd_done), 32'd0);

        // Both queues loaded: grants alternate starting with PD.
        do_reset();
        bus.pd_req_valid = 1'b1; bus.pd_req_cmd  = 4'b0100;
        bus.dbg_req_valid = 1'b1; bus.dbg_req_cmd = 4'b0100;
        tick_n(2);
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            wait_pending(v);
            chk($sformatf("alt_grant%0d", k), 32'(v), 32'(alt_exp[k % 2]));
            serve();
        end

        // Fill the PD queue while a grant is stalled awaiting accept.
        do_reset();
        bus.pd_req_valid = 1'b1; bus.pd_req_cmd = 4'b0100;
        tick();
        bus.pd_req_valid = 1'b0;
        wait_pending(v);
        chk("full_stall_grant", 32'(v), 32'h50);
        bus.pd_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.pd_req_cmd = full_cmds[i];
            tick();
        end
        bus.pd_req_cmd = 4'b0111;
        chk("full_ready_low", 32'(bus.pd_req_ready), 32'd0);
        tick();
        chk("full_fifth_blocked", 32'(bus.pd_req_ready), 32'd0);
        bus.pd_req_valid = 1'b0;
        serve();
        for (int i = 0; i < 4; i++) begin
            wait_pending(v);
            chk($sformatf("full_drain%0d", i), 32'(v), 32'(full_exp[i]));
            if (i == 0) chk("full_ready_back", 32'(bus.pd_req_ready), 32'd1);
            serve();
        end
        tick_n(6);
        chk("full_no_fifth", 32'(bus.pending_auth_request), 32'h00);

        // Invalid role is dropped; the next DEBUG entry is granted right after.
        do_reset();
        bus.dbg_req_valid = 1'b1; bus.dbg_req_cmd = 4'b1100;
        tick();
        bus.dbg_req_cmd = 4'b0100;
        tick();
        bus.dbg_req_valid = 1'b0;
        tick();
        chk("err_pulse", 32'(bus.cmd_err), 32'd1);
        chk("err_pending", 32'(bus.pending_auth_request), 32'h00);
        tick();
        chk("err_pulse_end", 32'(bus.cmd_err), 32'd0);
        chk("err_next_grant", 32'(bus.pending_auth_request), 32'h90);
        serve();

        // Accept timeout, then a queued request proceeds; done on the expiry cycle wins.
        do_reset();
        bus.pd_req_valid = 1'b1; bus.pd_req_cmd = 4'b0100;
        tick();
        bus.pd_req_cmd = 4'b1000;
        tick();
        bus.pd_req_valid = 1'b0;
        wait_pending(v);
        chk("tout_grant", 32'(v), 32'h50);
        tick_n(TOUT - 1);
        chk("tout_pre_pending", 32'(bus.pending_auth_request), 32'h50);
        chk("tout_pre_err", 32'(bus.timeout_err), 32'd0);
        tick();
        chk("tout_err", 32'(bus.timeout_err), 32'd1);
        chk("tout_pending", 32'(bus.pending_auth_request), 32'h00);
        chk("tout_release_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("tout_idle", 32'(bus.busy), 32'd0);
        wait_pending(v);
        chk("tout_next_grant", 32'(v), 32'h60);
        bus.PD_in_ready = 1'b1;
        tick();
        bus.PD_in_ready = 1'b0;
        tick_n(TOUT - 1);
        chk("edge_busy", 32'(bus.busy), 32'd1);
        bus.auth_msg_ready = 1'b1;
        tick();
        bus.auth_msg_ready = 1'b0;
        chk("edge_done", 32'(bus.pd_done), 32'd1);
        chk("edge_no_tout", 32'(bus.timeout_err), 32'd0);
        tick_n(2);

        // Reset while awaiting completion drops everything.
        do_reset();
        bus.pd_req_valid = 1'b1; bus.pd_req_cmd = 4'b0100;
        tick();
        bus.pd_req_valid = 1'b0;
        wait_pending(v);
        bus.PD_in_ready = 1'b1;
        tick();
        bus.PD_in_ready = 1'b0;
        bus.pd_req_valid = 1'b1; bus.dbg_req_valid = 1'b1; bus.dbg_req_cmd = 4'b1000;
        tick();
        idle_inputs();
        reset = 1'b1;
        bus.auth_msg_ready = 1'b1;
        tick();
        reset = 1'b0;
        bus.auth_msg_ready = 1'b0;
        chk("rst_pending", 32'(bus.pending_auth_request), 32'h00);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pd_ready", 32'(bus.pd_req_ready), 32'd1);
        chk("rst_dbg_ready", 32'(bus.dbg_req_ready), 32'd1);
        chk("rst_no_done", 32'(bus.pd_done), 32'd0);
        tick_n(6);
        chk("rst_queues_empty", 32'(bus.pending_auth_request), 32'h00);

        // Random traffic, checked only by the per-cycle model compare.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset              = ($urandom_range(0, 499) == 0);
            bus.pd_req_valid   = 1'($urandom_range(0, 1));
            bus.pd_req_cmd     = 4'($urandom);
            bus.dbg_req_valid  = 1'($urandom_range(0, 1));
            bus.dbg_req_cmd    = 4'($urandom);
            bus.PD_in_ready    = ($urandom_range(0, 3) == 0);
            bus.DEBUG_in_ready = ($urandom_range(0, 3) == 0);
            bus.auth_msg_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick_n(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
